// File: rtl/regfile_bytelane.sv
// Parametrised byte-lane register file with a sequenced clear, optional
// write-to-read forwarding and a ready indication for the pipeline.
module regfile_bytelane #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned BYPASS = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_clr_req,
    output logic                  o_ready,
    input  logic [DATA_W/8-1:0]   i_wen,
    input  logic [ADDR_W-1:0]     i_waddr,
    input  logic [DATA_W-1:0]     i_wdata,
    input  logic [ADDR_W-1:0]     i_raddr1,
    input  logic [DATA_W/8-1:0]   i_rbe1,
    output logic [DATA_W-1:0]     o_rdata1,
    input  logic [ADDR_W-1:0]     i_raddr2,
    input  logic [DATA_W/8-1:0]   i_rbe2,
    output logic [DATA_W-1:0]     o_rdata2,
    input  logic [ADDR_W-1:0]     i_test_addr,
    output logic [DATA_W-1:0]     o_test_data
);

    localparam int unsigned BYTES = DATA_W / 8;
    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam logic        BYP_EN = (BYPASS != 0);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(1);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_clr_idx;
    logic [ADDR_W-1:0]   w_clr_idx_nxt;
    logic                w_ready;
    logic                w_clr_we;
    logic                w_user_we;
    logic                w_byp_ok;
    logic [DATA_W-1:0]   r_rf [DEPTH];

    // State register; reset restarts the clear sweep at register 1
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= ST_CLEAR;
            r_clr_idx <= FIRST_IDX;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_idx <= w_clr_idx_nxt;
        end
    end

    // Next-state and control decode
    always_comb begin
        w_state_nxt   = r_state;
        w_clr_idx_nxt = r_clr_idx;
        w_ready       = 1'b0;
        w_clr_we      = 1'b0;
        w_user_we     = 1'b0;
        unique case (r_state)
            ST_CLEAR: begin
                w_clr_we = 1'b1;
                if (r_clr_idx == LAST_IDX) begin
                    w_state_nxt = ST_READY;
                end else begin
                    w_clr_idx_nxt = r_clr_idx + ADDR_W'(1);
                end
            end
            ST_READY: begin
                w_ready = 1'b1;
                if (i_clr_req) begin
                    w_state_nxt   = ST_CLEAR;
                    w_clr_idx_nxt = FIRST_IDX;
                end else begin
                    w_user_we = 1'b1;
                end
            end
            default: begin
                w_state_nxt   = ST_CLEAR;
                w_clr_idx_nxt = FIRST_IDX;
            end
        endcase
    end

    // Storage update: clear sweep or per-lane user write; register 0 never written
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            if (w_clr_we) begin
                r_rf[r_clr_idx] <= '0;
            end else if (w_user_we && (i_waddr != '0)) begin
                for (int unsigned i = 0; i < BYTES; i++) begin
                    if (i_wen[i]) begin
                        r_rf[i_waddr][i*8 +: 8] <= i_wdata[i*8 +: 8];
                    end
                end
            end
        end
    end

    function automatic logic [DATA_W-1:0] f_read(
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] word,
        input logic [BYTES-1:0]  be,
        input logic              byp,
        input logic [BYTES-1:0]  wen,
        input logic [DATA_W-1:0] wdata,
        input logic              rdy
    );
        logic [DATA_W-1:0] src;
        logic [DATA_W-1:0] res;
        src = (addr == '0) ? '0 : word;
        res = '0;
        for (int unsigned i = 0; i < BYTES; i++) begin
            if (byp && wen[i]) begin
                src[i*8 +: 8] = wdata[i*8 +: 8];
            end
            if (be[i]) begin
                res[i*8 +: 8] = src[i*8 +: 8];
            end
        end
        return rdy ? res : '0;
    endfunction

    // Forwarding only when this cycle's write will actually land
    assign w_byp_ok = BYP_EN && w_ready && !i_clr_req && (i_waddr != '0);

    assign o_ready     = w_ready;
    assign o_rdata1    = f_read(i_raddr1, r_rf[i_raddr1], i_rbe1,
                                w_byp_ok && (i_waddr == i_raddr1), i_wen, i_wdata, w_ready);
    assign o_rdata2    = f_read(i_raddr2, r_rf[i_raddr2], i_rbe2,
                                w_byp_ok && (i_waddr == i_raddr2), i_wen, i_wdata, w_ready);
    assign o_test_data = f_read(i_test_addr, r_rf[i_test_addr], {BYTES{1'b1}},
                                1'b0, i_wen, i_wdata, w_ready);

endmodule

// File: tb/tb_regfile_bytelane.sv
// Bench for regfile_bytelane: directed scenarios plus randomized traffic
// against a behavioural array model; one instance with forwarding, one without.
module tb_regfile_bytelane;

    logic        clk;
    logic        rst, clr_req;
    logic [3:0]  wen, rbe1, rbe2;
    logic [4:0]  waddr, raddr1, raddr2, test_addr;
    logic [31:0] wdata;
    logic        ready, nb_ready;
    logic [31:0] rd1, rd2, td, nb_rd1, nb_rd2, nb_td;

    logic [31:0] m_rf [32];
    bit          m_clearing;
    int          m_pos;
    int          n_vec, n_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    regfile_bytelane #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) dut (
        .i_clk(clk), .i_rst(rst), .i_clr_req(clr_req), .o_ready(ready),
        .i_wen(wen), .i_waddr(waddr), .i_wdata(wdata),
        .i_raddr1(raddr1), .i_rbe1(rbe1), .o_rdata1(rd1),
        .i_raddr2(raddr2), .i_rbe2(rbe2), .o_rdata2(rd2),
        .i_test_addr(test_addr), .o_test_data(td)
    );

    regfile_bytelane #(.DATA_W(32), .ADDR_W(5), .BYPASS(0)) dut_nb (
        .i_clk(clk), .i_rst(rst), .i_clr_req(clr_req), .o_ready(nb_ready),
        .i_wen(wen), .i_waddr(waddr), .i_wdata(wdata),
        .i_raddr1(raddr1), .i_rbe1(rbe1), .o_rdata1(nb_rd1),
        .i_raddr2(raddr2), .i_rbe2(rbe2), .o_rdata2(nb_rd2),
        .i_test_addr(test_addr), .o_test_data(nb_td)
    );

    // Advance the model with the inputs present at this edge, then the clock
    task automatic tick();
        if (rst) begin
            m_clearing = 1'b1;
            m_pos      = 1;
        end else if (m_clearing) begin
            m_rf[m_pos] = 32'h0;
            if (m_pos == 31) m_clearing = 1'b0;
            else m_pos++;
        end else if (clr_req) begin
            m_clearing = 1'b1;
            m_pos      = 1;
        end else if (waddr != 5'd0) begin
            for (int i = 0; i < 4; i++)
                if (wen[i]) m_rf[waddr][8*i +: 8] = wdata[8*i +: 8];
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] a, input logic [3:0] be, input bit byp);
        logic [31:0] s;
        logic [31:0] r;
        if (m_clearing) return 32'h0;
        s = (a == 5'd0) ? 32'h0 : m_rf[a];
        if (byp && !clr_req && waddr == a && a != 5'd0)
            for (int i = 0; i < 4; i++)
                if (wen[i]) s[8*i +: 8] = wdata[8*i +: 8];
        r = 32'h0;
        for (int i = 0; i < 4; i++)
            if (be[i]) r[8*i +: 8] = s[8*i +: 8];
        return r;
    endfunction

    task automatic idle();
        clr_req = 0; wen = 0; waddr = 0; wdata = 0;
        raddr1 = 0; rbe1 = 4'hF; raddr2 = 0; rbe2 = 4'hF; test_addr = 0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1;
        tick();
        tick();
        n_vec++;
        if (ready !== 1'b0 || nb_ready !== 1'b0 || td !== 32'h0) begin
            n_err++;
            $display("FAIL reset_hold: ready=%b nb_ready=%b td=%h, want 0 0 0", ready, nb_ready, td);
        end
        rst = 0;
        for (int k = 1; k <= 31; k++) begin
            tick();
            n_vec++;
            if (ready !== (k == 31) || nb_ready !== (k == 31)) begin
                n_err++;
                $display("FAIL reset_ready edge%0d: ready=%b nb=%b, want %b", k, ready, nb_ready, k == 31);
            end
        end
        for (int a = 0; a < 32; a++) begin
            test_addr = 5'(a);
            #1;
            n_vec++;
            if (td !== 32'h0 || nb_td !== 32'h0) begin
                n_err++;
                $display("FAIL reset_cleared r%0d: td=%h nb_td=%h, want 0", a, td, nb_td);
            end
        end
    endtask

    task automatic test_partial_write();
        idle();
        waddr = 5; wen = 4'hF; wdata = 32'h11223344;
        tick();
        wen = 4'b0010; wdata = 32'hAABBCCDD;
        tick();
        idle();
        raddr1 = 5; rbe1 = 4'hF;
        #1;
        n_vec++;
        if (rd1 !== 32'h1122CC44 || nb_rd1 !== 32'h1122CC44) begin
            n_err++;
            $display("FAIL partial_write: rd1=%h nb_rd1=%h, want 1122cc44", rd1, nb_rd1);
        end
    endtask

    task automatic test_read_masks();
        idle();
        raddr1 = 5; rbe1 = 4'b0011; raddr2 = 5; rbe2 = 4'b1100;
        #1;
        n_vec++;
        if (rd1 !== 32'h0000CC44) begin
            n_err++;
            $display("FAIL mask_port1: rd1=%h, want 0000cc44", rd1);
        end
        n_vec++;
        if (rd2 !== 32'h11220000) begin
            n_err++;
            $display("FAIL mask_port2: rd2=%h, want 11220000", rd2);
        end
    endtask

    task automatic test_r0_and_bypass();
        idle();
        waddr = 0; wen = 4'hF; wdata = 32'hFFFFFFFF; raddr1 = 0;
        #1;
        n_vec++;
        if (rd1 !== 32'h0) begin
            n_err++;
            $display("FAIL r0_same_cycle: rd1=%h, want 0", rd1);
        end
        tick();
        wen = 0;
        #1;
        n_vec++;
        if (rd1 !== 32'h0 || td !== 32'h0) begin
            n_err++;
            $display("FAIL r0_after: rd1=%h td=%h, want 0", rd1, td);
        end
        waddr = 7; wen = 4'hF; wdata = 32'h12345678;
        tick();
        wen = 4'b0001; wdata = 32'h000000EE; raddr2 = 7; rbe2 = 4'hF; test_addr = 7;
        #1;
        n_vec++;
        if (rd2 !== 32'h123456EE) begin
            n_err++;
            $display("FAIL bypass_on: rd2=%h, want 123456ee", rd2);
        end
        n_vec++;
        if (nb_rd2 !== 32'h12345678 || td !== 32'h12345678) begin
            n_err++;
            $display("FAIL bypass_off: nb_rd2=%h td=%h, want 12345678", nb_rd2, td);
        end
        tick();
        wen = 0;
        #1;
        n_vec++;
        if (rd2 !== 32'h123456EE || nb_rd2 !== 32'h123456EE) begin
            n_err++;
            $display("FAIL bypass_after_edge: rd2=%h nb_rd2=%h, want 123456ee", rd2, nb_rd2);
        end
    endtask

    task automatic test_random(input int cycles);
        logic [31:0] e1, e2, et, n1, n2;
        for (int c = 0; c < cycles; c++) begin
            clr_req   = ($urandom_range(0, 59) == 0);
            wen       = 4'($urandom);
            waddr     = 5'($urandom);
            wdata     = $urandom;
            raddr1    = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom);
            raddr2    = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom);
            rbe1      = 4'($urandom);
            rbe2      = 4'($urandom);
            test_addr = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom);
            #1;
            e1 = exp_rd(raddr1, rbe1, 1'b1);
            e2 = exp_rd(raddr2, rbe2, 1'b1);
            n1 = exp_rd(raddr1, rbe1, 1'b0);
            n2 = exp_rd(raddr2, rbe2, 1'b0);
            et = exp_rd(test_addr, 4'hF, 1'b0);
            n_vec++;
            if (ready !== !m_clearing || nb_ready !== !m_clearing || rd1 !== e1 || rd2 !== e2 ||
                nb_rd1 !== n1 || nb_rd2 !== n2 || td !== et || nb_td !== et) begin
                n_err++;
                $display("FAIL random cyc%0d: rdy=%b rd1=%h rd2=%h nb1=%h nb2=%h td=%h, want rdy=%b %h %h %h %h %h",
                         c, ready, rd1, rd2, nb_rd1, nb_rd2, td, !m_clearing, e1, e2, n1, n2, et);
            end
            tick();
        end
        idle();
        while (m_clearing) tick();
    endtask

    task automatic test_midrun_clear();
        idle();
        waddr = 3; wen = 4'hF; wdata = 32'hCAFEF00D;
        tick();
        clr_req = 1; wdata = 32'hDEADBEEF;
        tick();
        clr_req = 0;
        #1;
        n_vec++;
        if (ready !== 1'b0) begin
            n_err++;
            $display("FAIL clear_start: ready=%b, want 0", ready);
        end
        for (int k = 1; k <= 31; k++) begin
            waddr = 5'($urandom_range(1, 31)); wen = 4'hF; wdata = $urandom;
            clr_req = ($urandom_range(0, 1) == 1);
            raddr1 = waddr;
            #1;
            n_vec++;
            if (rd1 !== 32'h0 || td !== 32'h0) begin
                n_err++;
                $display("FAIL clear_reads k%0d: rd1=%h td=%h, want 0", k, rd1, td);
            end
            tick();
            n_vec++;
            if (ready !== (k == 31)) begin
                n_err++;
                $display("FAIL clear_ready k%0d: ready=%b, want %b", k, ready, k == 31);
            end
        end
        idle();
        for (int a = 0; a < 32; a++) begin
            raddr1 = 5'(a); test_addr = 5'(a);
            #1;
            n_vec++;
            if (rd1 !== 32'h0 || td !== 32'h0) begin
                n_err++;
                $display("FAIL clear_result r%0d: rd1=%h td=%h, want 0", a, rd1, td);
            end
        end
    endtask

    task automatic test_reset_during_clear();
        idle();
        clr_req = 1;
        tick();
        clr_req = 0;
        for (int k = 0; k < 9; k++) tick();
        rst = 1;
        tick();
        rst = 0;
        for (int k = 1; k <= 31; k++) begin
            tick();
            n_vec++;
            if (ready !== (k == 31) || nb_ready !== (k == 31)) begin
                n_err++;
                $display("FAIL rst_in_clear edge%0d: ready=%b nb=%b, want %b", k, ready, nb_ready, k == 31);
            end
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        m_clearing = 1'b1;
        m_pos = 1;
        for (int a = 0; a < 32; a++) m_rf[a] = 32'h0;
        rst = 1;
        idle();
        test_reset();
        test_partial_write();
        test_read_masks();
        test_r0_and_bypass();
        test_random(400);
        test_midrun_clear();
        test_reset_during_clear();
        test_random(300);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_bytelane.md
Name: regfile_bytelane

Overview:
- Parametrised successor to the single-cycle 32x32 register file: configurable data width and depth, per-port byte read masks, and true byte-lane writes that preserve unwritten bytes.
- Adds a post-reset/on-demand clear sequencer FSM, an optional write-to-read bypass and a ready/busy indication.
- Sits between the decode/writeback stages and the board debug display (test port).

Parameters:
- DATA_W, 32, register width in bits; must be a multiple of 8.
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers.
- BYTES, DATA_W/8, number of byte lanes (derived localparam, not overridable).
- BYPASS, 1, 1 = same-cycle write data is forwarded to the read ports; 0 = reads return array contents only.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- clr_req  in  1  request a full clear of registers 1..DEPTH-1.
- ready  out  1  1 = normal operation; 0 = clear in progress.
- wen  in  BYTES  byte-lane write enables; bit i covers wdata[8i+7:8i].
- waddr  in  ADDR_W  write address.
- wdata  in  DATA_W  write data.
- raddr1  in  ADDR_W  read port 1 address.
- rbe1  in  BYTES  read port 1 byte mask.
- rdata1  out  DATA_W  read port 1 data, combinational.
- raddr2  in  ADDR_W  read port 2 address.
- rbe2  in  BYTES  read port 2 byte mask.
- rdata2  out  DATA_W  read port 2 data, combinational.
- test_addr  in  ADDR_W  debug read address.
- test_data  out  DATA_W  debug read data, combinational, full width, unmasked.

Behaviour:
- Storage: DEPTH x DATA_W array. Register 0 always reads 0; writes to it are discarded.
- FSM states:
  - CLEAR: ready=0, clr_idx counter.
  - READY: ready=1.
- Reset: rst=1 at an edge puts the FSM in CLEAR with clr_idx=1. While rst=1 the FSM stays there: ready=0, and no array write occurs.
- CLEAR (rst=0), at each edge:
  - rf[clr_idx] is set to 0.
  - If clr_idx==DEPTH-1, go to READY; else clr_idx increments.
  - ready therefore rises exactly DEPTH-1 edges after rst deasserts (31 for the defaults).
- Writes and clear requests:
  - User writes are ignored in CLEAR.
  - clr_req is ignored in CLEAR.
  - rst has priority over everything.
- READY, at each edge:
  - If clr_req=1: go to CLEAR with clr_idx=1; any write in the same cycle is dropped.
  - Else, for each lane i with wen[i]=1 and waddr!=0: rf[waddr] lane i <= wdata lane i.
  - Lanes with wen[i]=0 keep their old value; they are NOT zeroed.
  - wen=0 is a no-op.
- Reads:
  - Lane i of rdataN = (rbeN[i] ? src lane i : 8'h00).
  - src = 0 if raddrN==0, else rf[raddrN].
  - While ready=0, rdata1, rdata2 and test_data are all 0.
- Bypass (BYPASS=1):
  - Applies when ready=1, clr_req=0, waddr==raddrN and waddr!=0.
  - src lane i = wdata lane i where wen[i]=1, else the stored lane.
  - The merged value is visible in the same cycle.
  - With BYPASS=0, the new value appears only after the edge.
- test_data: same src rule as the read ports, with all lanes enabled; no bypass.
- Width rules: no arithmetic. clr_idx is ADDR_W bits wide and never wraps past DEPTH-1.

Test Plan:
- Reset, then release -> ready=0 for 31 edges and rises on the 31st; afterwards test_data=0 for every test_addr 0..31.
- Partial write: write r5=0x11223344 with wen=4'hF, then write wen=4'b0010 wdata=0xAABBCCDD -> rdata1 (raddr1=5, rbe1=F) = 0x1122CC44.
- Read masks: r5=0x1122CC44, rbe1=4'b0011, rbe2=4'b1100, both ports at r5 -> rdata1=0x0000CC44, rdata2=0x11220000.
- r0 and bypass (BYPASS=1):
  - Write r0=0xFFFFFFFF -> rdata1 stays 0.
  - Same cycle waddr=raddr2=7, wen=4'b0001, wdata=0x000000EE, r7 previously 0x12345678 -> rdata2=0x123456EE before the edge.
  - With BYPASS=0 -> rdata2=0x12345678 until the edge.
- Mid-run clear: in READY assert clr_req for one cycle with a write to r3 -> ready=0 next cycle, r3 write dropped; writes during CLEAR ignored; after 31 edges ready=1 and all regs read 0.
- Reset during CLEAR: assert rst at clr_idx=10 -> sequence restarts; ready rises 31 edges after rst deasserts.
